rvfi_trace_collector: RTL and testbench

// - Multi-retire RVFI monitor: accepts up to NRET retire events per cycle from a Sodor-class core,

---
 rtl/rvfi_trace_pkg.sv | 48 ++++
 rtl/rvfi_trace_fifo.sv | 61 ++++++
 rtl/rvfi_trace_collector.sv | 206 ++++++++++++++++++++
 tb/tb_rvfi_trace_collector.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvfi_trace_pkg.sv
// Shared types and helpers for the RVFI trace collector: packet layout,
// memory size codes, opcodes that never write rd, and byte-mask helpers.
package rvfi_trace_pkg;

    localparam logic [1:0] MEM_SZ_NONE = 2'b00;
    localparam logic [1:0] MEM_SZ_B    = 2'b01;
    localparam logic [1:0] MEM_SZ_H    = 2'b10;
    localparam logic [1:0] MEM_SZ_W    = 2'b11;

    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef struct packed {
        logic [63:0] order;
        logic [31:0] insn;
        logic        trap;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [31:0] rs1_rdata;
        logic [31:0] rs2_rdata;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic [31:0] pc_rdata;
        logic [31:0] pc_wdata;
        logic [31:0] mem_addr;
        logic [3:0]  mem_rmask;
        logic [3:0]  mem_wmask;
        logic [31:0] mem_rdata;
        logic [31:0] mem_wdata;
    } rvfi_pkt_t;

    // Bytes beyond lane 3 are truncated away: misaligned accesses lose their upper bytes.
    function automatic logic [3:0] mem_mask(input logic [1:0] size, input logic [1:0] offset);
        logic [3:0] base;
        case (size)
            MEM_SZ_B: base = 4'b0001;
            MEM_SZ_H: base = 4'b0011;
            MEM_SZ_W: base = 4'b1111;
            default:  base = 4'b0000;
        endcase
        return base << offset;
    endfunction

    function automatic logic [31:0] byte_lanes(input logic [3:0] mask);
        return {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
    endfunction

endpackage

// File: rtl/rvfi_trace_fifo.sv
// Packet FIFO taking up to NRET compacted packets per cycle and giving one per cycle.
// Slot storage has no reset; the registered pointers and count define what is live.
module rvfi_trace_fifo
    import rvfi_trace_pkg::*;
#(
    parameter int unsigned NRET  = 2,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned PushW = $clog2(NRET + 1),
    localparam int unsigned CntW  = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [PushW-1:0] push_cnt,
    input  rvfi_pkt_t        wr_data [NRET],
    input  logic             pop,
    output rvfi_pkt_t        rd_data,
    output logic [CntW-1:0]  count
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned SelW = (NRET > 1) ? $clog2(NRET) : 1;

    logic [PtrW-1:0] wptr_q, rptr_q;
    logic [CntW-1:0] count_q;
    logic            pop_en;
    rvfi_pkt_t       slot_rd [DEPTH];

    for (genvar s = 0; s < DEPTH; s++) begin : g_slot
        rvfi_pkt_t       slot_q;
        logic [PtrW-1:0] off;

        // Distance of this slot past the write pointer selects which compacted packet lands here.
        assign off = PtrW'(s) - wptr_q;

        always_ff @(posedge clock) begin
            if (int'(off) < int'(push_cnt)) begin
                slot_q <= wr_data[off[SelW-1:0]];
            end
        end

        assign slot_rd[s] = slot_q;
    end

    assign pop_en = pop && (count_q != '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_q + PtrW'(push_cnt);
            rptr_q  <= rptr_q + PtrW'(pop_en);
            count_q <= count_q + CntW'(push_cnt) - CntW'(pop_en);
        end
    end

    assign rd_data = slot_rd[rptr_q];
    assign count   = count_q;

endmodule

// File: rtl/rvfi_trace_collector.sv
// Multi-retire RVFI monitor: builds one packet per retire strobe, queues them in
// program order and presents one packet per cycle on a valid/ready RVFI port.
module rvfi_trace_collector
    import rvfi_trace_pkg::*;
#(
    parameter int unsigned NRET       = 2,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned DROP_CNT_W = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [NRET-1:0]       retire,
    input  logic [NRET*32-1:0]    instruction,
    input  logic [NRET*32-1:0]    rs1_rdata,
    input  logic [NRET*32-1:0]    rs2_rdata,
    input  logic [NRET*32-1:0]    rd_wdata,
    input  logic [NRET*32-1:0]    pc_rdata,
    input  logic [NRET*32-1:0]    pc_wdata,
    input  logic [NRET-1:0]       exception,
    input  logic [NRET-1:0]       mem_req,
    input  logic [NRET-1:0]       mem_we,
    input  logic [NRET*3-1:0]     mem_be,
    input  logic [NRET*32-1:0]    mem_addr,
    input  logic [NRET*32-1:0]    mem_rdata,
    input  logic [NRET*32-1:0]    mem_wdata,
    output logic                  in_ready,
    input  logic                  rvfi_ready,
    output logic                  rvfi_valid,
    output logic [63:0]           rvfi_order,
    output logic [31:0]           rvfi_insn,
    output logic                  rvfi_trap,
    output logic                  rvfi_halt,
    output logic                  rvfi_intr,
    output logic [1:0]            rvfi_mode,
    output logic [1:0]            rvfi_ixl,
    output logic [4:0]            rvfi_rs1_addr,
    output logic [4:0]            rvfi_rs2_addr,
    output logic [4:0]            rvfi_rs3_addr,
    output logic [31:0]           rvfi_rs1_rdata,
    output logic [31:0]           rvfi_rs2_rdata,
    output logic [31:0]           rvfi_rs3_rdata,
    output logic [4:0]            rvfi_rd_addr,
    output logic [31:0]           rvfi_rd_wdata,
    output logic [31:0]           rvfi_pc_rdata,
    output logic [31:0]           rvfi_pc_wdata,
    output logic [31:0]           rvfi_mem_addr,
    output logic [3:0]            rvfi_mem_rmask,
    output logic [3:0]            rvfi_mem_wmask,
    output logic [31:0]           rvfi_mem_rdata,
    output logic [31:0]           rvfi_mem_wdata,
    output logic                  overflow,
    output logic [DROP_CNT_W-1:0] drop_count
);

    localparam int unsigned PushW = $clog2(NRET + 1);
    localparam int unsigned CntW  = $clog2(DEPTH + 1);

    function automatic rvfi_pkt_t build_pkt(
        input logic [31:0] insn, rs1_val, rs2_val, rd_val, pc_r, pc_w,
        input logic        trap, req, we,
        input logic [1:0]  size,
        input logic [31:0] addr, rdata, wdata
    );
        rvfi_pkt_t   p;
        logic [3:0]  mask;
        logic [31:0] lanes;
        p           = '0;
        p.insn      = insn;
        p.trap      = trap;
        p.rs1_addr  = insn[19:15];
        p.rs2_addr  = insn[24:20];
        p.rd_addr   = (insn[6:0] == OPC_STORE || insn[6:0] == OPC_BRANCH) ? 5'd0 : insn[11:7];
        p.rs1_rdata = (p.rs1_addr == 5'd0) ? 32'd0 : rs1_val;
        p.rs2_rdata = (p.rs2_addr == 5'd0) ? 32'd0 : rs2_val;
        p.rd_wdata  = (p.rd_addr == 5'd0) ? 32'd0 : rd_val;
        p.pc_rdata  = pc_r;
        p.pc_wdata  = pc_w;
        mask        = mem_mask(size, addr[1:0]);
        lanes       = byte_lanes(mask);
        if (req && size != MEM_SZ_NONE) begin
            p.mem_addr = addr;
            if (we) begin
                p.mem_wmask = mask;
                p.mem_wdata = wdata & lanes;
            end else begin
                p.mem_rmask = mask;
                p.mem_rdata = rdata & lanes;
            end
        end
        return p;
    endfunction

    logic [63:0]           order_ctr_q;
    logic                  overflow_q;
    logic [DROP_CNT_W-1:0] drop_count_q, drop_count_d;
    logic [DROP_CNT_W:0]   drop_sum;
    logic [PushW-1:0]      rank [NRET];
    logic [PushW-1:0]      n_ret, push_cnt;
    logic [CntW-1:0]       count;
    logic                  drop;
    rvfi_pkt_t             pkt [NRET];
    rvfi_pkt_t             wr_data [NRET];
    rvfi_pkt_t             head, shown;
    logic                  unused_be_unsigned;

    // Signedness of loads is not part of the RVFI packet.
    assign unused_be_unsigned = ^mem_be;

    always_comb begin : c_rank
        logic [PushW-1:0] acc;
        acc = '0;
        for (int i = 0; i < NRET; i++) begin
            rank[i] = acc;
            acc     = acc + PushW'(retire[i]);
        end
        n_ret = acc;
    end

    always_comb begin
        for (int i = 0; i < NRET; i++) begin
            pkt[i] = build_pkt(instruction[32*i +: 32], rs1_rdata[32*i +: 32],
                               rs2_rdata[32*i +: 32], rd_wdata[32*i +: 32],
                               pc_rdata[32*i +: 32], pc_wdata[32*i +: 32],
                               exception[i], mem_req[i], mem_we[i], mem_be[3*i +: 2],
                               mem_addr[32*i +: 32], mem_rdata[32*i +: 32],
                               mem_wdata[32*i +: 32]);
            pkt[i].order = order_ctr_q + 64'(rank[i]);
        end
    end

    // Compact strobed channels into consecutive write lanes, oldest first.
    always_comb begin
        for (int j = 0; j < NRET; j++) begin
            wr_data[j] = '0;
            for (int i = 0; i < NRET; i++) begin
                if (retire[i] && rank[i] == PushW'(j)) begin
                    wr_data[j] = pkt[i];
                end
            end
        end
    end

    assign in_ready     = (32'(count) + NRET) <= DEPTH;
    assign push_cnt     = in_ready ? n_ret : '0;
    assign drop         = (n_ret != '0) && !in_ready;
    assign drop_sum     = {1'b0, drop_count_q} + (DROP_CNT_W + 1)'(n_ret);
    assign drop_count_d = drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            order_ctr_q  <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            order_ctr_q <= order_ctr_q + 64'(n_ret);
            if (drop) begin
                overflow_q   <= 1'b1;
                drop_count_q <= drop_count_d;
            end
        end
    end

    rvfi_trace_fifo #(
        .NRET  (NRET),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset_n  (reset_n),
        .push_cnt (push_cnt),
        .wr_data  (wr_data),
        .pop      (rvfi_valid && rvfi_ready),
        .rd_data  (head),
        .count    (count)
    );

    assign rvfi_valid = (count != '0);
    assign shown      = rvfi_valid ? head : '0;

    assign rvfi_order     = shown.order;
    assign rvfi_insn      = shown.insn;
    assign rvfi_trap      = shown.trap;
    assign rvfi_rs1_addr  = shown.rs1_addr;
    assign rvfi_rs2_addr  = shown.rs2_addr;
    assign rvfi_rs1_rdata = shown.rs1_rdata;
    assign rvfi_rs2_rdata = shown.rs2_rdata;
    assign rvfi_rd_addr   = shown.rd_addr;
    assign rvfi_rd_wdata  = shown.rd_wdata;
    assign rvfi_pc_rdata  = shown.pc_rdata;
    assign rvfi_pc_wdata  = shown.pc_wdata;
    assign rvfi_mem_addr  = shown.mem_addr;
    assign rvfi_mem_rmask = shown.mem_rmask;
    assign rvfi_mem_wmask = shown.mem_wmask;
    assign rvfi_mem_rdata = shown.mem_rdata;
    assign rvfi_mem_wdata = shown.mem_wdata;

    assign rvfi_halt      = 1'b0;
    assign rvfi_intr      = 1'b0;
    assign rvfi_mode      = 2'b00;
    assign rvfi_ixl       = 2'b00;
    assign rvfi_rs3_addr  = 5'd0;
    assign rvfi_rs3_rdata = 32'd0;

    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_rvfi_trace_collector.sv
// Self-checking bench: directed table, hand-written corner sequences and random
// traffic, all compared against a queue-based reference model of the collector.
module tb_rvfi_trace_collector;

    localparam int NR = 2;
    localparam int DP = 8;

    logic clock = 1'b0;
    logic reset_n;
    logic [NR-1:0]    retire, exception, mem_req, mem_we;
    logic [NR*32-1:0] instruction, rs1_rdata, rs2_rdata, rd_wdata, pc_rdata, pc_wdata;
    logic [NR*32-1:0] mem_addr, mem_rdata, mem_wdata;
    logic [NR*3-1:0]  mem_be;
    logic             rvfi_ready;
    logic             in_ready, rvfi_valid, rvfi_trap, rvfi_halt, rvfi_intr, overflow;
    logic [63:0]      rvfi_order;
    logic [31:0]      rvfi_insn, rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rs3_rdata, rvfi_rd_wdata;
    logic [31:0]      rvfi_pc_rdata, rvfi_pc_wdata, rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata;
    logic [1:0]       rvfi_mode, rvfi_ixl;
    logic [4:0]       rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rs3_addr, rvfi_rd_addr;
    logic [3:0]       rvfi_mem_rmask, rvfi_mem_wmask;
    logic [15:0]      drop_count;

    always #5 clock = ~clock;

    rvfi_trace_collector #(.NRET(NR), .DEPTH(DP), .DROP_CNT_W(16)) dut (
        .clock(clock), .reset_n(reset_n), .retire(retire), .instruction(instruction),
        .rs1_rdata(rs1_rdata), .rs2_rdata(rs2_rdata), .rd_wdata(rd_wdata),
        .pc_rdata(pc_rdata), .pc_wdata(pc_wdata), .exception(exception),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .mem_wdata(mem_wdata), .in_ready(in_ready),
        .rvfi_ready(rvfi_ready), .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order),
        .rvfi_insn(rvfi_insn), .rvfi_trap(rvfi_trap), .rvfi_halt(rvfi_halt),
        .rvfi_intr(rvfi_intr), .rvfi_mode(rvfi_mode), .rvfi_ixl(rvfi_ixl),
        .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr),
        .rvfi_rs3_addr(rvfi_rs3_addr), .rvfi_rs1_rdata(rvfi_rs1_rdata),
        .rvfi_rs2_rdata(rvfi_rs2_rdata), .rvfi_rs3_rdata(rvfi_rs3_rdata),
        .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata),
        .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
        .rvfi_mem_addr(rvfi_mem_addr), .rvfi_mem_rmask(rvfi_mem_rmask),
        .rvfi_mem_wmask(rvfi_mem_wmask), .rvfi_mem_rdata(rvfi_mem_rdata),
        .rvfi_mem_wdata(rvfi_mem_wdata), .overflow(overflow), .drop_count(drop_count)
    );

    typedef struct packed {
        logic [63:0] order;
        logic [31:0] insn;
        logic        trap;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] rs1d, rs2d, rdw, pcr, pcw, maddr;
        logic [3:0]  rmask, wmask;
        logic [31:0] rdata, wdata;
    } exp_pkt_t;

    typedef struct {
        logic [1:0]  retire;
        logic [31:0] i0, i1;
        logic        ready;
        logic        exp_valid;
        logic [63:0] exp_order;
        logic [4:0]  exp_rd;
        logic        exp_ir;
    } vec_t;

    exp_pkt_t        mq[$];
    longint unsigned m_order;
    bit              m_ovf;
    int              m_drop;
    int              n_vec = 0;
    int              n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_pkt_t model_build(input int ch, input longint unsigned ord);
        exp_pkt_t    p;
        logic [31:0] w, a;
        logic [1:0]  sz;
        int          nb, off;
        p       = '0;
        w       = instruction[32*ch +: 32];
        p.order = ord;
        p.insn  = w;
        p.trap  = exception[ch];
        p.rs1   = w[19:15];
        p.rs2   = w[24:20];
        p.rd    = (w[6:0] == 7'h23 || w[6:0] == 7'h63) ? 5'd0 : w[11:7];
        p.rs1d  = (p.rs1 == 0) ? 32'd0 : rs1_rdata[32*ch +: 32];
        p.rs2d  = (p.rs2 == 0) ? 32'd0 : rs2_rdata[32*ch +: 32];
        p.rdw   = (p.rd == 0) ? 32'd0 : rd_wdata[32*ch +: 32];
        p.pcr   = pc_rdata[32*ch +: 32];
        p.pcw   = pc_wdata[32*ch +: 32];
        sz      = mem_be[3*ch +: 2];
        a       = mem_addr[32*ch +: 32];
        if (mem_req[ch] && sz != 2'b00) begin
            nb      = 1 << (int'(sz) - 1);
            off     = int'(a[1:0]);
            p.maddr = a;
            for (int b = 0; b < 4; b++) begin
                if (b >= off && b < off + nb) begin
                    if (mem_we[ch]) begin
                        p.wmask[b]          = 1'b1;
                        p.wdata[8*b +: 8]   = mem_wdata[32*ch + 8*b +: 8];
                    end else begin
                        p.rmask[b]          = 1'b1;
                        p.rdata[8*b +: 8]   = mem_rdata[32*ch + 8*b +: 8];
                    end
                end
            end
        end
        return p;
    endfunction

    // Model update for the coming rising edge, from pre-edge state and current inputs.
    task automatic model_step();
        bit ir;
        int n;
        ir = (DP - mq.size()) >= NR;
        n  = 0;
        if (rvfi_ready && mq.size() > 0) void'(mq.pop_front());
        for (int ch = 0; ch < NR; ch++) begin
            if (retire[ch]) begin
                if (ir) mq.push_back(model_build(ch, m_order + longint'(n)));
                n++;
            end
        end
        if (n > 0 && !ir) begin
            m_ovf  = 1'b1;
            m_drop = (m_drop + n > 65535) ? 65535 : m_drop + n;
        end
        m_order += longint'(n);
    endtask

    task automatic check();
        exp_pkt_t e;
        bit       v;
        v = mq.size() > 0;
        e = v ? mq[0] : '0;
        chk("valid", 64'(rvfi_valid), 64'(v));
        chk("in_ready", 64'(in_ready), 64'((DP - mq.size()) >= NR));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("drop_count", 64'(drop_count), 64'(m_drop));
        chk("order", rvfi_order, e.order);
        chk("insn", 64'(rvfi_insn), 64'(e.insn));
        chk("trap", 64'(rvfi_trap), 64'(e.trap));
        chk("rs_addr", 64'({rvfi_rs1_addr, rvfi_rs2_addr}), 64'({e.rs1, e.rs2}));
        chk("rs_rdata", {rvfi_rs1_rdata, rvfi_rs2_rdata}, {e.rs1d, e.rs2d});
        chk("rd", 64'({rvfi_rd_addr, rvfi_rd_wdata}), 64'({e.rd, e.rdw}));
        chk("pc", {rvfi_pc_rdata, rvfi_pc_wdata}, {e.pcr, e.pcw});
        chk("mem_addr_mask", 64'({rvfi_mem_addr, rvfi_mem_rmask, rvfi_mem_wmask}),
            64'({e.maddr, e.rmask, e.wmask}));
        chk("mem_data", {rvfi_mem_rdata, rvfi_mem_wdata}, {e.rdata, e.wdata});
        chk("const_zero", 64'({rvfi_halt, rvfi_intr, rvfi_mode, rvfi_ixl, rvfi_rs3_addr,
                               rvfi_rs3_rdata}), 64'd0);
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        @(negedge clock);
        check();
    endtask

    task automatic clear_inputs();
        retire = '0; instruction = '0; rs1_rdata = '0; rs2_rdata = '0; rd_wdata = '0;
        pc_rdata = '0; pc_wdata = '0; exception = '0; mem_req = '0; mem_we = '0;
        mem_be = '0; mem_addr = '0; mem_rdata = '0; mem_wdata = '0; rvfi_ready = 1'b1;
    endtask

    task automatic async_reset();
        #2 reset_n = 1'b0;
        mq.delete();
        m_order = 0; m_ovf = 1'b0; m_drop = 0;
        #1 check();
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    function automatic logic [31:0] rand_insn();
        logic [31:0] w;
        logic [6:0]  ops [5];
        ops = '{7'h13, 7'h03, 7'h23, 7'h63, 7'h33};
        w   = $urandom;
        w[6:0] = ops[$urandom_range(0, 4)];
        if ($urandom_range(0, 7) == 0) w[11:7] = 5'd0;
        if ($urandom_range(0, 7) == 0) w[19:15] = 5'd0;
        return w;
    endfunction

    task automatic rand_inputs(input int ready_pct);
        retire = 2'($urandom_range(0, 3));
        for (int ch = 0; ch < NR; ch++) begin
            instruction[32*ch +: 32] = rand_insn();
            rs1_rdata[32*ch +: 32]   = $urandom;
            rs2_rdata[32*ch +: 32]   = $urandom;
            rd_wdata[32*ch +: 32]    = $urandom;
            pc_rdata[32*ch +: 32]    = $urandom;
            pc_wdata[32*ch +: 32]    = $urandom;
            mem_addr[32*ch +: 32]    = $urandom;
            mem_rdata[32*ch +: 32]   = $urandom;
            mem_wdata[32*ch +: 32]   = $urandom;
            mem_be[3*ch +: 3]        = 3'($urandom);
        end
        exception  = 2'($urandom);
        mem_req    = 2'($urandom);
        mem_we     = 2'($urandom);
        rvfi_ready = ($urandom_range(0, 99) < ready_pct);
    endtask

    localparam logic [31:0] ADDI_X1 = 32'h00100093;
    localparam logic [31:0] ADDI_X2 = 32'h00200113;
    localparam logic [31:0] ADDI_X3 = 32'h00300193;
    localparam logic [31:0] ADDI_X4 = 32'h00400213;
    localparam logic [31:0] LB_X5   = 32'h00008283;
    localparam logic [31:0] SH_X2   = 32'h002092A3;

    vec_t vecs [6];

    initial begin
        vecs[0] = '{2'b11, ADDI_X1, ADDI_X2, 1'b1, 1'b1, 64'd0, 5'd1, 1'b1};
        vecs[1] = '{2'b00, ADDI_X1, ADDI_X2, 1'b1, 1'b1, 64'd1, 5'd2, 1'b1};
        vecs[2] = '{2'b00, ADDI_X1, ADDI_X2, 1'b1, 1'b0, 64'd0, 5'd0, 1'b1};
        vecs[3] = '{2'b10, ADDI_X4, ADDI_X3, 1'b1, 1'b1, 64'd2, 5'd3, 1'b1};
        vecs[4] = '{2'b01, ADDI_X4, ADDI_X3, 1'b1, 1'b1, 64'd3, 5'd4, 1'b1};
        vecs[5] = '{2'b00, ADDI_X4, ADDI_X3, 1'b1, 1'b0, 64'd0, 5'd0, 1'b1};

        reset_n = 1'b0;
        clear_inputs();
        mq.delete();
        m_order = 0; m_ovf = 1'b0; m_drop = 0;
        @(negedge clock);
        check();
        @(negedge clock);
        reset_n = 1'b1;
        tick();

        for (int k = 0; k < 6; k++) begin
            retire      = vecs[k].retire;
            instruction = {vecs[k].i1, vecs[k].i0};
            rd_wdata    = {32'h0000_2222, 32'h0000_1111};
            rvfi_ready  = vecs[k].ready;
            tick();
            chk($sformatf("vec%0d_valid", k), 64'(rvfi_valid), 64'(vecs[k].exp_valid));
            chk($sformatf("vec%0d_order", k), rvfi_order, vecs[k].exp_order);
            chk($sformatf("vec%0d_rd", k), 64'(rvfi_rd_addr), 64'(vecs[k].exp_rd));
            chk($sformatf("vec%0d_in_ready", k), 64'(in_ready), 64'(vecs[k].exp_ir));
        end

        // Byte load at the top lane of a word.
        clear_inputs();
        retire = 2'b01; instruction[31:0] = LB_X5;
        mem_req = 2'b01; mem_we = 2'b00; mem_be[2:0] = 3'b001;
        mem_addr[31:0] = 32'h0000_1003; mem_rdata[31:0] = 32'hAABB_CCDD;
        tick();
        chk("lb_rmask", 64'(rvfi_mem_rmask), 64'h8);
        chk("lb_rdata", 64'(rvfi_mem_rdata), 64'hAA00_0000);
        chk("lb_wmask", 64'(rvfi_mem_wmask), 64'h0);

        // Halfword store with nonzero imm[4:0] in the rd field.
        clear_inputs();
        retire = 2'b01; instruction[31:0] = SH_X2;
        mem_req = 2'b01; mem_we = 2'b01; mem_be[2:0] = 3'b010;
        mem_addr[31:0] = 32'h0000_2002; mem_wdata[31:0] = 32'h1234_5678;
        tick();
        chk("sh_wmask", 64'(rvfi_mem_wmask), 64'hC);
        chk("sh_wdata", 64'(rvfi_mem_wdata), 64'h1234_0000);
        chk("sh_rd", 64'(rvfi_rd_addr), 64'd0);
        chk("sh_rmask", 64'(rvfi_mem_rmask), 64'h0);
        clear_inputs();
        tick();

        // Fill with consumer stalled, then one dropped cycle, then drain.
        async_reset();
        clear_inputs();
        rvfi_ready = 1'b0; retire = 2'b11; instruction = {ADDI_X2, ADDI_X1};
        for (int k = 0; k < 5; k++) begin
            tick();
            if (k == 3) chk("full_in_ready", 64'(in_ready), 64'd0);
        end
        chk("ovf_flag", 64'(overflow), 64'd1);
        chk("ovf_drop_count", 64'(drop_count), 64'd2);
        retire = 2'b00; rvfi_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("drain_order%0d", k), rvfi_order, 64'(k));
            tick();
        end
        retire = 2'b01;
        tick();
        chk("post_gap_order", rvfi_order, 64'd10);

        clear_inputs();
        for (int c = 0; c < 3000; c++) begin
            rand_inputs((c / 500) % 2 == 0 ? 70 : 25);
            if (c == 1500) async_reset();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
